// File: rtl/ifm_window_gen_if.sv
// ---------------------------------------------------------------------------
// ifm_window_gen_if
// Pixel-stream / window bus between a raster pixel source and the 3x3 window
// generator.
//   stall        : downstream freeze (source -> generator)
//   clear        : synchronous frame abort (source -> generator)
//   pixel_in     : raster-order pixel byte
//   pixel_valid  : pixel_in is valid
//   pixel_ready  : generator can accept (combinational !stall)
//   ifm_window   : nine window bytes, index 3*r + c, [8] newest pixel
//   window_valid : ifm_window holds a complete window
//   frame_done   : one-cycle pulse on the last window of a frame
// master = pixel source / downstream side, slave = window generator.
// ---------------------------------------------------------------------------
interface ifm_window_gen_if;
  logic            stall;
  logic            clear;
  logic [7:0]      pixel_in;
  logic            pixel_valid;
  logic            pixel_ready;
  logic [8:0][7:0] ifm_window;
  logic            window_valid;
  logic            frame_done;

  modport master (
    output stall, clear, pixel_in, pixel_valid,
    input  pixel_ready, ifm_window, window_valid, frame_done
  );

  modport slave (
    input  stall, clear, pixel_in, pixel_valid,
    output pixel_ready, ifm_window, window_valid, frame_done
  );
endinterface

// File: rtl/ifm_window_gen.sv
// ---------------------------------------------------------------------------
// ifm_window_gen
// Builds 3x3 "valid" convolution windows from a raster-order byte stream.
// Two line buffers hold the previous two rows; a 3x3 shift window advances on
// every accepted pixel. All state freezes under stall; clear aborts a frame.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   io_win : window bus (slave side), see ifm_window_gen_if
// ---------------------------------------------------------------------------
module ifm_window_gen #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic              clk,
  input  logic              rst,
  ifm_window_gen_if.slave   io_win
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_lb0 [IMG_W];   // row-2
  logic [7:0]      r_lb1 [IMG_W];   // row-1
  logic [8:0][7:0] r_win;
  logic            r_win_valid;
  logic            r_frame_done;

  logic            w_accept;
  logic [7:0]      w_lb0_rd;
  logic [7:0]      w_lb1_rd;

  // clear is folded in here so neither buffers nor window move on an abort.
  assign w_accept = io_win.pixel_valid && !io_win.stall && !io_win.clear;
  assign w_lb0_rd = r_lb0[r_col];
  assign w_lb1_rd = r_lb1[r_col];

  assign io_win.pixel_ready  = !io_win.stall;
  assign io_win.ifm_window   = r_win;
  assign io_win.window_valid = r_win_valid;
  assign io_win.frame_done   = r_frame_done;

  // Position counters plus window_valid / frame_done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= {CW{1'b0}};
      r_row        <= {RW{1'b0}};
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (io_win.clear) begin
      r_col        <= {CW{1'b0}};
      r_row        <= {RW{1'b0}};
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (io_win.stall) begin
      // freeze together with the downstream stage
    end else if (w_accept) begin
      // Flags use the position of the pixel being accepted (pre-increment).
      r_win_valid  <= (r_row >= ROW_TWO) && (r_col >= COL_TWO);
      r_frame_done <= (r_row == ROW_LAST) && (r_col == COL_LAST);
      if (r_col == COL_LAST) begin
        r_col <= {CW{1'b0}};
        r_row <= (r_row == ROW_LAST) ? {RW{1'b0}} : r_row + ROW_ONE;
      end else begin
        r_col <= r_col + COL_ONE;
      end
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  // Line buffers: old values were read combinationally above, so the write
  // below is naturally read-before-write at the same address. Not reset:
  // rows 0-1 of every frame never produce a valid window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= w_lb1_rd;
      r_lb1[r_col] <= io_win.pixel_in;
    end
  end

  // 3x3 shift window: each row moves left, new column 2 from buffers/pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win <= '0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb0_rd;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb1_rd;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= io_win.pixel_in;
    end else begin
      r_win <= r_win;
    end
  end

endmodule
